// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer for ALU results: each entry carries the opcode,
// result and flags as one unit, plus a sticky overflow indicator for the consumer.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [W-1:0]               in_out,
  input  logic                       in_cout,
  input  logic                       in_overflow,
  input  logic                       in_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_op,
  output logic [W-1:0]               out_result,
  output logic                       out_cout,
  output logic                       out_overflow,
  output logic                       out_zero,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       sticky_ovf,
  input  logic                       sticky_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = W + 6;

  // Handshake: a transfer happens on an edge where valid && ready are both high;
  // ready depends only on registered state, never on the partner's valid/ready.
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_sticky;

  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_head;

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_wdata   = {in_op, in_out, in_cout, in_overflow, in_zero};

  // Storage is left unreset; the output mask below hides stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A set from an overflowing push takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_push && in_overflow) begin
      r_sticky <= 1'b1;
    end else if (sticky_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;
  assign {out_op, out_result, out_cout, out_overflow, out_zero} = w_head;
  assign count      = r_count;
  assign sticky_ovf = r_sticky;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed vector table, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int W     = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid, in_ready, in_cout, in_overflow, in_zero;
  logic [2:0]     in_op;
  logic [W-1:0]   in_out;
  logic           out_valid, out_ready, out_cout, out_overflow, out_zero;
  logic [2:0]     out_op;
  logic [W-1:0]   out_result;
  logic [CW-1:0]  count;
  logic           sticky_ovf, sticky_clr;

  alu_result_fifo #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_out(in_out),
    .in_cout(in_cout), .in_overflow(in_overflow), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_result(out_result),
    .out_cout(out_cout), .out_overflow(out_overflow), .out_zero(out_zero),
    .count(count), .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic iv, input logic [2:0] op, input logic [W-1:0] res,
                       input logic c, input logic o, input logic z,
                       input logic ordy, input logic clr);
    in_valid = iv; in_op = op; in_out = res;
    in_cout = c; in_overflow = o; in_zero = z;
    out_ready = ordy; sticky_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Snapshot layout: {count, out_valid, in_ready, op, result, cout, ovf, zero, sticky}
  function automatic logic [63:0] snap();
    return 64'({count, out_valid, in_ready, out_op, out_result,
                out_cout, out_overflow, out_zero, sticky_ovf});
  endfunction

  function automatic logic [63:0] mk_exp(input int cnt, input logic ov, input logic ir,
                                         input logic [2:0] op, input logic [W-1:0] res,
                                         input logic [2:0] flg, input logic st);
    logic [CW-1:0] c;
    c = CW'(cnt);
    return 64'({c, ov, ir, op, res, flg, st});
  endfunction

  typedef struct {
    logic          iv;
    logic [2:0]    op;
    logic [W-1:0]  res;
    logic [2:0]    flg_in;   // {cout, overflow, zero}
    logic          ordy;
    logic          clr;
    logic [63:0]   exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [2:0] op, input logic [W-1:0] res,
                     input logic [2:0] fi, input logic ordy, input logic clr,
                     input int ecnt, input logic eov, input logic eir,
                     input logic [2:0] eop, input logic [W-1:0] eres,
                     input logic [2:0] eflg, input logic est);
    vec_t v;
    v.iv = iv; v.op = op; v.res = res; v.flg_in = fi; v.ordy = ordy; v.clr = clr;
    v.exp = mk_exp(ecnt, eov, eir, eop, eres, eflg, est);
    vecs.push_back(v);
  endtask

  // scoreboard
  logic [W-1:0]   exp_q[$];
  logic [W+5:0]   model_q[$];
  logic           model_sticky;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // reset state while held in reset
    #12;
    chk("reset_state", snap(), mk_exp(0, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // single entry, sticky clear, pop, pop on empty
    add(1, 0, 4'h3, 3'b110, 0, 0,   1, 1, 1, 0, 4'h3, 3'b110, 1);
    add(0, 0, 4'h0, 3'b000, 0, 1,   1, 1, 1, 0, 4'h3, 3'b110, 0);
    add(0, 0, 4'h0, 3'b000, 1, 0,   0, 0, 1, 0, 4'h0, 3'b000, 0);
    add(0, 0, 4'h0, 3'b000, 1, 0,   0, 0, 1, 0, 4'h0, 3'b000, 0);
    // fill with 8 offers, only 4 accepted
    add(1, 0, 4'h1, 3'b000, 0, 0,   1, 1, 1, 0, 4'h1, 3'b000, 0);
    add(1, 1, 4'h2, 3'b100, 0, 0,   2, 1, 1, 0, 4'h1, 3'b000, 0);
    add(1, 2, 4'h3, 3'b001, 0, 0,   3, 1, 1, 0, 4'h1, 3'b000, 0);
    add(1, 3, 4'h4, 3'b101, 0, 0,   4, 1, 0, 0, 4'h1, 3'b000, 0);
    add(1, 4, 4'h5, 3'b000, 0, 0,   4, 1, 0, 0, 4'h1, 3'b000, 0);
    add(1, 5, 4'h6, 3'b100, 0, 0,   4, 1, 0, 0, 4'h1, 3'b000, 0);
    add(1, 6, 4'h7, 3'b001, 0, 0,   4, 1, 0, 0, 4'h1, 3'b000, 0);
    add(1, 7, 4'h8, 3'b101, 0, 0,   4, 1, 0, 0, 4'h1, 3'b000, 0);
    // drain in order
    add(0, 0, 4'h0, 3'b000, 1, 0,   3, 1, 1, 1, 4'h2, 3'b100, 0);
    add(0, 0, 4'h0, 3'b000, 1, 0,   2, 1, 1, 2, 4'h3, 3'b001, 0);
    add(0, 0, 4'h0, 3'b000, 1, 0,   1, 1, 1, 3, 4'h4, 3'b101, 0);
    add(0, 0, 4'h0, 3'b000, 1, 0,   0, 0, 1, 0, 4'h0, 3'b000, 0);
    // full with simultaneous pop: pop only, then push next cycle
    add(1, 4, 4'h5, 3'b000, 0, 0,   1, 1, 1, 4, 4'h5, 3'b000, 0);
    add(1, 5, 4'h6, 3'b100, 0, 0,   2, 1, 1, 4, 4'h5, 3'b000, 0);
    add(1, 6, 4'h7, 3'b001, 0, 0,   3, 1, 1, 4, 4'h5, 3'b000, 0);
    add(1, 7, 4'h8, 3'b101, 0, 0,   4, 1, 0, 4, 4'h5, 3'b000, 0);
    add(1, 1, 4'h2, 3'b100, 1, 0,   3, 1, 1, 5, 4'h6, 3'b100, 0);
    add(1, 1, 4'h2, 3'b100, 0, 0,   4, 1, 0, 5, 4'h6, 3'b100, 0);
    add(0, 0, 4'h0, 3'b000, 1, 0,   3, 1, 1, 6, 4'h7, 3'b001, 0);
    add(0, 0, 4'h0, 3'b000, 1, 0,   2, 1, 1, 7, 4'h8, 3'b101, 0);
    add(0, 0, 4'h0, 3'b000, 1, 0,   1, 1, 1, 1, 4'h2, 3'b100, 0);
    add(0, 0, 4'h0, 3'b000, 1, 0,   0, 0, 1, 0, 4'h0, 3'b000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].op, vecs[i].res, vecs[i].flg_in[2], vecs[i].flg_in[1],
            vecs[i].flg_in[0], vecs[i].ordy, vecs[i].clr);
      step();
      chk($sformatf("vec%0d", i), snap(), vecs[i].exp);
    end

    // sticky priority: set wins over clear, then clear alone
    drive(1, 2, 4'h9, 3'b0, 1, 0, 0, 1);
    step();
    chk("sticky_set_wins", {63'b0, sticky_ovf}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    chk("sticky_clear", {63'b0, sticky_ovf}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk("sticky_seq_empty", 64'(count), 64'd0);

    // streaming: continuous push and pop for 20 cycles
    begin
      int pops;
      pops = 0;
      for (int i = 0; i < 21; i++) begin
        if (i < 20) drive(1, 3'(i), W'(i), 0, 0, 0, 1, 0);
        else        drive(0, 0, 0, 0, 0, 0, 1, 0);
        if (out_valid) begin
          chk($sformatf("stream_val%0d", pops), 64'(out_result), 64'(exp_q.pop_front()));
          pops++;
        end
        if (i < 20) exp_q.push_back(W'(i));
        step();
        if (i < 20) chk($sformatf("stream_cnt%0d", i), 64'(count), 64'd1);
      end
      chk("stream_pops", 64'(pops), 64'd20);
      chk("stream_empty", 64'(out_valid), 64'd0);
    end

    // reset mid-operation with three entries stored
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'(i), 4'hA + W'(i), 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_cnt", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", snap(), mk_exp(0, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 6, 4'hE, 3'b0, 0, 1, 0, 0);
    step();
    chk("first_push_after_reset", snap(), mk_exp(1, 1, 1, 6, 4'hE, 3'b001, 0));
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();

    // randomized run against a queue model
    model_q.delete();
    model_sticky = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic iv, ordy, clr, c, o, z, push, pop;
      logic [2:0] op;
      logic [W-1:0] res;
      logic [W+5:0] head;
      iv   = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < 45);
      clr  = ($urandom_range(0, 9) == 0);
      op   = 3'($urandom);
      res  = W'($urandom);
      c = 1'($urandom); o = ($urandom_range(0, 7) == 0); z = 1'($urandom);
      drive(iv, op, res, c, o, z, ordy, clr);
      head = (model_q.size() > 0) ? model_q[0] : '0;
      #1;
      chk($sformatf("rand%0d", i), snap(),
          mk_exp(model_q.size(), model_q.size() > 0, model_q.size() < DEPTH,
                 head[W+5:W+3], head[W+2:3], head[2:0], model_sticky));
      push = iv && (model_q.size() < DEPTH);
      pop  = ordy && (model_q.size() > 0);
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back({op, res, c, o, z});
      if (push && o) model_sticky = 1'b1;
      else if (clr)  model_sticky = 1'b0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered ALU result entries; SHALL be a power of two, 2 to 16.
REQ-002 Parameter W, default 4, ALU result width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 in_valid  input  1  ALU result presented this cycle.
REQ-006 in_ready  output  1  buffer can accept an entry this cycle.
REQ-007 in_op  input  3  opcode that produced the result.
REQ-008 in_out  input  W  ALU result.
REQ-009 in_cout, in_overflow, in_zero  input  1 each  ALU carry-out, overflow and zero flags.
REQ-010 out_valid  output  1  head entry is available.
REQ-011 out_ready  input  1  consumer takes the head entry this cycle.
REQ-012 out_op  output  3, out_result  output  W, out_cout/out_overflow/out_zero  output  1 each  head entry fields.
REQ-013 count  output  clog2(DEPTH+1)  number of stored entries.
REQ-014 sticky_ovf  output  1  an overflow result has been accepted since the last clear.
REQ-015 sticky_clr  input  1  clears sticky_ovf.

Function
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 Each entry SHALL store {in_op, in_out, in_cout, in_overflow, in_zero} as one unit, and the entry SHALL be returned unmodified.
REQ-018 Entries SHALL be delivered in strict arrival order.
REQ-019 in_ready SHALL be 1 exactly when count < DEPTH; it SHALL be registered-state derived, with no combinational path from out_ready.
REQ-020 out_valid SHALL be 1 exactly when count > 0.
REQ-021 The head entry SHALL be presented first-word-fall-through; push-to-out_valid latency SHALL be 1 cycle into an empty buffer, with no same-cycle bypass.
REQ-022 When out_valid = 0, out_op, out_result, out_cout, out_overflow and out_zero SHALL all drive 0.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, advance both pointers, and lose no data.
REQ-024 When full, in_ready = 0, so no push SHALL occur even if a pop happens that same cycle.
REQ-025 When the buffer is empty, out_ready SHALL have no effect.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-027 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-028 sticky_ovf SHALL be set on any push with in_overflow = 1.
REQ-029 sticky_clr SHALL clear sticky_ovf on the next edge.
REQ-030 If a set (REQ-028) and sticky_clr occur in the same cycle, the set SHALL win and sticky_ovf SHALL be 1.
REQ-031 in_valid with in_ready = 0 SHALL be ignored and SHALL NOT alter state.

Reset
REQ-032 While rst_n = 0, count SHALL be 0, pointers 0, out_valid 0, in_ready 1, sticky_ovf 0, and all out_* data 0, independent of clk.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries immediately.
REQ-034 Storage array contents need no reset, because REQ-022 masks them.
REQ-035 The first push SHALL be accepted on the first rising edge after rst_n rises.

Verification
REQ-036 Single entry: push {op=000, out=0011, cout=1, ovf=1, zero=0} into an empty buffer -> next cycle out_valid=1, out_result=0011, out_cout=1, out_overflow=1, count=1, sticky_ovf=1.
REQ-037 Fill and order: push 8 results, ops 000..111, with out_ready=0 (DEPTH=4) -> only ops 000..011 accepted, in_ready=0 after the 4th push, count=4; drain -> ops 000,001,010,011 in order, then out_valid=0 and all out_* = 0.
REQ-038 Full with simultaneous pop: count=4, in_valid=1, out_ready=1 for one cycle -> one pop, no push, count=3; next cycle the push is accepted and count=4.
REQ-039 Streaming: in_valid=1 and out_ready=1 continuously for 20 cycles with incrementing out values -> count stays at 1, every value appears exactly once in order, and pointers wrap correctly.
REQ-040 Sticky priority: sticky_clr=1 in the same cycle as a push with in_overflow=1 -> sticky_ovf=1; a later sticky_clr with no overflow push -> sticky_ovf=0.
REQ-041 Reset mid-operation: count=3, then rst_n=0 between clock edges -> out_valid=0, count=0, in_ready=1, and out_result=0000 immediately.
